// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard unit: forward-select encodings, W-stage
// tnew and default MDU latencies.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // A result in W is always ready; TNEW_W only names that stage's depth.
  typedef enum logic [2:0] {
    TNEW_0 = 3'd0,
    TNEW_1 = 3'd1,
    TNEW_2 = 3'd2,
    TNEW_W = 3'd3
  } tnew_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Width needed to hold the longer of the two MDU latencies.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard unit: D-stage sources, E/M/W write-back
// info, MDU start strobe, and the stall/forward results.
interface hazard_ctrl_if;
  logic [4:0] a1_d;
  logic [4:0] a2_d;
  logic [2:0] tuse_rs_d;
  logic [2:0] tuse_rt_d;
  logic       md_use_d;
  logic [4:0] a3_e;
  logic       regwrite_e;
  logic [2:0] tnew_e;
  logic [4:0] a3_m;
  logic       regwrite_m;
  logic [2:0] tnew_m;
  logic [4:0] a3_w;
  logic       regwrite_w;
  logic       md_start_e;
  logic       md_div_e;
  logic       stall;
  logic       md_busy;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;

  modport master (
    output a1_d, a2_d, tuse_rs_d, tuse_rt_d, md_use_d,
    output a3_e, regwrite_e, tnew_e, a3_m, regwrite_m, tnew_m,
    output a3_w, regwrite_w, md_start_e, md_div_e,
    input  stall, md_busy, fwd_rs_d, fwd_rt_d
  );

  modport slave (
    input  a1_d, a2_d, tuse_rs_d, tuse_rt_d, md_use_d,
    input  a3_e, regwrite_e, tnew_e, a3_m, regwrite_m, tnew_m,
    input  a3_w, regwrite_w, md_start_e, md_div_e,
    output stall, md_busy, fwd_rs_d, fwd_rt_d
  );
endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// MDU countdown: loads the mult/div latency on a start pulse while idle and
// counts down to zero; busy while non-zero.
module md_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [W-1:0] md_cnt_q;
  logic [W-1:0] md_cnt_d;

  // A start while counting is dropped: the stall keeps a second MDU op out of E.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end else if (load) begin
      md_cnt_d = is_div ? W'(DIV_CYCLES) : W'(MULT_CYCLES);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) md_cnt_q <= '0;
    else       md_cnt_q <= md_cnt_d;
  end

  assign busy = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: D-stage stall and forward selects plus MDU busy tracking.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic src_match(input logic [4:0] src, input logic [4:0] a3,
                                     input logic rw);
    return rw && (a3 == src) && (src != 5'd0);
  endfunction

  function automatic fwd_sel_e fwd_pick(input logic hit_e, input logic hit_m,
                                        input logic hit_w, input logic [2:0] tnew_e,
                                        input logic [2:0] tnew_m);
    if (hit_e && tnew_e == 3'd0)      return FWD_E;
    else if (hit_m && tnew_m == 3'd0) return FWD_M;
    else if (hit_w)                   return FWD_W;
    else                              return FWD_RF;
  endfunction

  logic e_rs, m_rs, w_rs, e_rt, m_rt, w_rt;
  logic stall_rs, stall_rt, stall_md, stall;
  logic md_busy;

  assign e_rs = src_match(hz.a1_d, hz.a3_e, hz.regwrite_e);
  assign m_rs = src_match(hz.a1_d, hz.a3_m, hz.regwrite_m);
  assign w_rs = src_match(hz.a1_d, hz.a3_w, hz.regwrite_w);
  assign e_rt = src_match(hz.a2_d, hz.a3_e, hz.regwrite_e);
  assign m_rt = src_match(hz.a2_d, hz.a3_m, hz.regwrite_m);
  assign w_rt = src_match(hz.a2_d, hz.a3_w, hz.regwrite_w);

  // W has already produced its value, so only E and M can force a wait.
  assign stall_rs = (e_rs && (hz.tnew_e > hz.tuse_rs_d)) ||
                    (m_rs && (hz.tnew_m > hz.tuse_rs_d));
  assign stall_rt = (e_rt && (hz.tnew_e > hz.tuse_rt_d)) ||
                    (m_rt && (hz.tnew_m > hz.tuse_rt_d));

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (hz.md_start_e),
    .is_div (hz.md_div_e),
    .busy   (md_busy)
  );

  // The start cycle itself counts: the MDU is claimed before the timer loads.
  assign stall_md = hz.md_use_d && (md_busy || hz.md_start_e);
  assign stall    = stall_rs || stall_rt || stall_md;

  assign hz.stall    = stall;
  assign hz.md_busy  = md_busy;
  assign hz.fwd_rs_d = fwd_pick(e_rs, m_rs, w_rs, hz.tnew_e, hz.tnew_m);
  assign hz.fwd_rt_d = fwd_pick(e_rt, m_rt, w_rt, hz.tnew_e, hz.tnew_m);

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Saturate rather than wrap so a long run never reads back as few stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cases then random traffic against a
// behavioural model of the stall/forward rules and MDU busy window.
module tb_hazard_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hz        (hz),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: cycle index, MDU busy window, stall tally.
  int cyc = 0;
  int md_start_cyc = 0;
  int md_len = 0;
  int model_cnt = 0;

  function automatic bit m_busy();
    return (md_len != 0) && (cyc > md_start_cyc) && (cyc <= md_start_cyc + md_len);
  endfunction

  function automatic bit m_hit(input int src, input int a3, input bit rw);
    return rw && (src != 0) && (a3 == src);
  endfunction

  function automatic int m_fwd(input int src);
    if (m_hit(src, hz.a3_e, hz.regwrite_e) && hz.tnew_e == 0) return 1;
    if (m_hit(src, hz.a3_m, hz.regwrite_m) && hz.tnew_m == 0) return 2;
    if (m_hit(src, hz.a3_w, hz.regwrite_w)) return 3;
    return 0;
  endfunction

  function automatic bit m_data_stall(input int src, input int tuse);
    return (m_hit(src, hz.a3_e, hz.regwrite_e) && int'(hz.tnew_e) > tuse) ||
           (m_hit(src, hz.a3_m, hz.regwrite_m) && int'(hz.tnew_m) > tuse);
  endfunction

  function automatic bit m_stall();
    return m_data_stall(hz.a1_d, hz.tuse_rs_d) || m_data_stall(hz.a2_d, hz.tuse_rt_d) ||
           (hz.md_use_d && (m_busy() || hz.md_start_e));
  endfunction

  function automatic int m_cnt();
`ifdef HAZARD_STALL_CNT_EN
    return model_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, ".stall"},   32'(hz.stall),    32'(m_stall()));
    check({tag, ".md_busy"}, 32'(hz.md_busy),  32'(m_busy()));
    check({tag, ".fwd_rs"},  32'(hz.fwd_rs_d), 32'(m_fwd(hz.a1_d)));
    check({tag, ".fwd_rt"},  32'(hz.fwd_rt_d), 32'(m_fwd(hz.a2_d)));
    check({tag, ".cnt"},     32'(stall_cnt),   32'(m_cnt()));
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  // Crosses the active edge, folds it into the model, lands 1 time unit later.
  task automatic advance();
    bit st;
    bit bz;
    st = m_stall();
    bz = m_busy();
    @(posedge clk);
    if (!reset) begin
      if (st && model_cnt < CNT_MAX) model_cnt++;
      if (hz.md_start_e && !bz) begin
        md_start_cyc = cyc;
        md_len = hz.md_div_e ? DIV_N : MULT_N;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    hz.a1_d = '0; hz.a2_d = '0; hz.tuse_rs_d = '0; hz.tuse_rt_d = '0; hz.md_use_d = 1'b0;
    hz.a3_e = '0; hz.regwrite_e = 1'b0; hz.tnew_e = '0;
    hz.a3_m = '0; hz.regwrite_m = 1'b0; hz.tnew_m = '0;
    hz.a3_w = '0; hz.regwrite_w = 1'b0;
    hz.md_start_e = 1'b0; hz.md_div_e = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    md_len = 0;
    model_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int busy_seen;

  initial begin
    clear_inputs();
    reset = 1'b1;
    #3;
    check("rst.md_busy", 32'(hz.md_busy), 32'd0);
    check("rst.cnt",     32'(stall_cnt),  32'd0);
    check("rst.stall",   32'(hz.stall),   32'd0);
    check("rst.fwd_rs",  32'(hz.fwd_rs_d), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // E write not ready for an rs needed now; then needed a cycle later.
    hz.regwrite_e = 1'b1; hz.a3_e = 5'd1; hz.tnew_e = 3'd1; hz.a1_d = 5'd1; hz.tuse_rs_d = 3'd0;
    at_sample();
    check("t1a.stall",  32'(hz.stall),    32'd1);
    check("t1a.fwd_rs", 32'(hz.fwd_rs_d), 32'd0);
    model_check("t1a");
    advance();
    hz.tuse_rs_d = 3'd1;
    at_sample();
    check("t1b.stall", 32'(hz.stall), 32'd0);
    model_check("t1b");
    advance();

    // Forward priority E > M > W on rt.
    clear_inputs();
    hz.a2_d = 5'd5;
    hz.regwrite_e = 1'b1; hz.a3_e = 5'd5; hz.tnew_e = 3'd0;
    hz.regwrite_m = 1'b1; hz.a3_m = 5'd5; hz.tnew_m = 3'd0;
    at_sample();
    check("t2a.fwd_rt", 32'(hz.fwd_rt_d), 32'd1);
    check("t2a.stall",  32'(hz.stall),    32'd0);
    model_check("t2a");
    advance();
    hz.regwrite_e = 1'b0;
    at_sample();
    check("t2b.fwd_rt", 32'(hz.fwd_rt_d), 32'd2);
    model_check("t2b");
    advance();
    hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b1; hz.a3_w = 5'd5;
    at_sample();
    check("t2c.fwd_rt", 32'(hz.fwd_rt_d), 32'd3);
    model_check("t2c");
    advance();

    // Register 0 never matches.
    clear_inputs();
    hz.regwrite_e = 1'b1; hz.a3_e = 5'd0; hz.tnew_e = 3'd2; hz.a1_d = 5'd0;
    at_sample();
    check("t3.stall",  32'(hz.stall),    32'd0);
    check("t3.fwd_rs", 32'(hz.fwd_rs_d), 32'd0);
    model_check("t3");
    advance();

    // Mult start with an MDU user held in D.
    clear_inputs();
    hz.md_use_d = 1'b1; hz.md_start_e = 1'b1; hz.md_div_e = 1'b0;
    at_sample();
    check("t4s.stall",   32'(hz.stall),   32'd1);
    check("t4s.md_busy", 32'(hz.md_busy), 32'd0);
    model_check("t4s");
    advance();
    hz.md_start_e = 1'b0;
    for (int i = 0; i < MULT_N; i++) begin
      at_sample();
      check($sformatf("t4b%0d.stall", i),   32'(hz.stall),   32'd1);
      check($sformatf("t4b%0d.md_busy", i), 32'(hz.md_busy), 32'd1);
      model_check("t4b");
      advance();
    end
    at_sample();
    check("t4e.stall",   32'(hz.stall),   32'd0);
    check("t4e.md_busy", 32'(hz.md_busy), 32'd0);
    model_check("t4e");
    advance();

    // Div start, asynchronous reset during the third busy cycle.
    clear_inputs();
    hz.md_start_e = 1'b1; hz.md_div_e = 1'b1;
    at_sample();
    model_check("t5s");
    advance();
    hz.md_start_e = 1'b0; hz.md_div_e = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_sample();
      model_check("t5b");
      advance();
    end
    at_sample();
    check("t5pre.md_busy", 32'(hz.md_busy), 32'd1);
    #2;
    reset = 1'b1;
    md_len = 0;
    model_cnt = 0;
    #1;
    check("t5rst.md_busy", 32'(hz.md_busy), 32'd0);
    check("t5rst.stall",   32'(hz.stall),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hz.md_start_e = 1'b1;
    at_sample();
    model_check("t5m");
    advance();
    hz.md_start_e = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < MULT_N + 3; i++) begin
      at_sample();
      if (hz.md_busy === 1'b1) busy_seen++;
      model_check("t5w");
      advance();
    end
    check("t5.busy_cycles", 32'(busy_seen), 32'(MULT_N));

    // Stall counter: 7 data-stall cycles, then run into saturation.
    clear_inputs();
    do_reset();
    hz.regwrite_e = 1'b1; hz.a3_e = 5'd2; hz.a1_d = 5'd2; hz.tnew_e = 3'd2;
    for (int i = 0; i < 7; i++) begin
      at_sample();
      model_check("t6a");
      advance();
    end
    at_sample();
`ifdef HAZARD_STALL_CNT_EN
    check("t6.cnt7", 32'(stall_cnt), 32'd7);
`else
    check("t6.cnt7", 32'(stall_cnt), 32'd0);
`endif
    advance();
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      at_sample();
      model_check("t6s");
      advance();
    end
    at_sample();
`ifdef HAZARD_STALL_CNT_EN
    check("t6.sat", 32'(stall_cnt), 32'(CNT_MAX));
`else
    check("t6.sat", 32'(stall_cnt), 32'd0);
`endif
    advance();

    // Random traffic on a small register window to provoke matches.
    clear_inputs();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      hz.a1_d = 5'($urandom_range(0, 3));
      hz.a2_d = 5'($urandom_range(0, 3));
      hz.tuse_rs_d = 3'($urandom_range(0, 3));
      hz.tuse_rt_d = 3'($urandom_range(0, 3));
      hz.a3_e = 5'($urandom_range(0, 3));
      hz.a3_m = 5'($urandom_range(0, 3));
      hz.a3_w = 5'($urandom_range(0, 3));
      hz.regwrite_e = 1'($urandom_range(0, 1));
      hz.regwrite_m = 1'($urandom_range(0, 1));
      hz.regwrite_w = 1'($urandom_range(0, 1));
      hz.tnew_e = 3'($urandom_range(0, 2));
      hz.tnew_m = 3'($urandom_range(0, 1));
      hz.md_use_d = ($urandom_range(0, 3) == 0);
      hz.md_start_e = ($urandom_range(0, 9) == 0);
      hz.md_div_e = 1'($urandom_range(0, 1));
      at_sample();
      model_check("rnd");
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
